// File: rtl/tpu_pkg.sv
// Shared TPU constants and types.
//   DATA_SIZE  bits per weight (also used by mac_matrix)
//   MAC_WIDTH  systolic matrix edge; N = MAC_WIDTH*MAC_WIDTH request lanes
//   fetch_state_e  weight fetch FSM encoding
package tpu_pkg;

  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned MAC_WIDTH = 8;
  localparam int unsigned N         = MAC_WIDTH * MAC_WIDTH;
  localparam int unsigned IDX_W     = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } fetch_state_e;

  // Lane index increment with wrap at N.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i    request vector
//   ptr_i    lane with highest priority; search runs upward with wrap
//   grant_c  one-hot grant of the picked lane
//   idx_c    encoded index of the picked lane
//   any_c    at least one request present
module rr_arbiter
  import tpu_pkg::*;
#(
  parameter int unsigned NREQ = N,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_c,
  output logic [IW-1:0]   idx_c,
  output logic            any_c
);

  logic [IW:0] pos;

  // First set bit at or above ptr_i, wrapping at NREQ.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (IW+1)'(ptr_i) + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (!any_c && req_i[pos[IW-1:0]]) begin
        any_c = 1'b1;
        idx_c = pos[IW-1:0];
      end
    end
    if (any_c) grant_c = NREQ'(1) << idx_c;
  end

endmodule

// File: rtl/weight_fetch_unit.sv
// Serves per-MAC weight requests from the weight SRAM, plus a bulk refill sweep.
//   clock, reset             clock / async active-low reset
//   weights_request          level request per MAC lane (row*MAC_WIDTH+col)
//   weights_data_out         packed lane weights, lane i at [i*DATA_SIZE +: DATA_SIZE]
//   weights_ack              one-hot, one-cycle pulse: lane just updated
//   tile_base                SRAM base of the current tile, sampled at pick
//   load_all / load_done     bulk refill command (IDLE only) / completion pulse
//   busy                     high whenever not IDLE
//   mem_rd_en/mem_addr/mem_rd_data  SRAM read port, data one cycle after strobe
module weight_fetch_unit
  import tpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N-1:0]              weights_request,
  output logic [N*DATA_SIZE-1:0]    weights_data_out,
  output logic [N-1:0]              weights_ack,
  input  logic [ADDR_WIDTH-1:0]     tile_base,
  input  logic                      load_all,
  output logic                      load_done,
  output logic                      busy,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [DATA_SIZE-1:0]      mem_rd_data
);

  fetch_state_e            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, rr_ptr_q, rr_ptr_d, arb_idx;
  logic [N-1:0]            sel_q, sel_d, ack_q, ack_d, arb_grant, pending;
  logic                    arb_any, bulk_q, bulk_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d, addr_q, addr_d;
  logic                    rd_en_q, rd_en_d, done_q, done_d, busy_q, wr_en;
  logic [N*DATA_SIZE-1:0]  lanes_q;

  // The lane acked this cycle is still requesting; keep it out of the pick.
  assign pending = weights_request & ~ack_q;

  rr_arbiter #(.NREQ(N)) u_arb (
    .req_i   (pending),
    .ptr_i   (rr_ptr_q),
    .grant_c (arb_grant),
    .idx_c   (arb_idx),
    .any_c   (arb_any)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    bulk_d   = bulk_q;
    base_d   = base_q;
    addr_d   = addr_q;
    rd_en_d  = 1'b0;
    ack_d    = '0;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_all) begin
          bulk_d  = 1'b1;
          idx_d   = '0;
          sel_d   = N'(1);
          base_d  = tile_base;
          addr_d  = tile_base;
          rd_en_d = 1'b1;
          state_d = ISSUE;
        end else if (arb_any) begin
          idx_d   = arb_idx;
          sel_d   = arb_grant;
          base_d  = tile_base;
          addr_d  = tile_base + ADDR_WIDTH'(arb_idx);
          rd_en_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        wr_en = 1'b1;
        ack_d = sel_q;
        if (!bulk_q) begin
          rr_ptr_d = wrap_inc(idx_q);
          state_d  = IDLE;
        end else if (idx_q == IDX_W'(N - 1)) begin
          bulk_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // Sweep continues straight into the next read from the latched base.
          idx_d   = wrap_inc(idx_q);
          sel_d   = sel_q << 1;
          addr_d  = base_q + ADDR_WIDTH'(wrap_inc(idx_q));
          rd_en_d = 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and lane registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      bulk_q   <= 1'b0;
      base_q   <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      ack_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      lanes_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      bulk_q   <= bulk_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
      if (wr_en) lanes_q[int'(idx_q) * DATA_SIZE +: DATA_SIZE] <= mem_rd_data;
    end
  end

  assign weights_data_out = lanes_q;
  assign weights_ack      = ack_q;
  assign load_done        = done_q;
  assign busy             = busy_q;
  assign mem_rd_en        = rd_en_q;
  assign mem_addr         = addr_q;

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Scoreboard bench for weight_fetch_unit: a transaction-level model predicts
// reads and acks at pick time; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_weight_fetch_unit;

  localparam int DW = 8;
  localparam int NL = 64;
  localparam int AW = 12;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NL-1:0]    weights_request = '0;
  logic [NL*DW-1:0] weights_data_out;
  logic [NL-1:0]    weights_ack;
  logic [AW-1:0]    tile_base = '0;
  logic             load_all = 1'b0;
  logic             load_done, busy, mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_rd_data = '0;

  weight_fetch_unit #(.ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .weights_request  (weights_request),
    .weights_data_out (weights_data_out),
    .weights_ack      (weights_ack),
    .tile_base        (tile_base),
    .load_all         (load_all),
    .load_done        (load_done),
    .busy             (busy),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_rd_data      (mem_rd_data)
  );

  initial forever #5 clock = ~clock;

  typedef struct { int lane; logic [DW-1:0] data; int cyc; bit done; } ack_exp_t;
  typedef struct { logic [AW-1:0] addr; int cyc; } rd_exp_t;

  ack_exp_t      ackq[$];
  rd_exp_t       rdq[$];
  logic [DW-1:0] sram [4096];
  logic [DW-1:0] mlanes [NL];
  int cyc = 0, free_at = 0, busy_start = 0, mask_cyc = -1, mask_lane = 0, mptr = 0;
  int checks = 0, failures = 0, reads_seen = 0, busy_rise = 0;
  logic [NL-1:0] acked_accum = '0;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_bus(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    ackq.delete();
    rdq.delete();
    for (int i = 0; i < NL; i++) mlanes[i] = '0;
    free_at = 0; busy_start = 0; mask_cyc = -1; mptr = 0; acked_accum = '0;
  endfunction

  // SRAM: data one cycle after the strobe.
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= sram[mem_addr];

  // Reference model: decides each fetch when the unit is free.
  always @(posedge clock) begin
    logic [NL-1:0] pend;
    logic [AW-1:0] a;
    int lane;
    cyc++;
    if (reset && cyc >= free_at) begin
      pend = weights_request;
      if (cyc == mask_cyc) pend[mask_lane] = 1'b0;
      if (load_all) begin
        for (int i = 0; i < NL; i++) begin
          a = tile_base + AW'(i);
          ackq.push_back('{i, sram[a], cyc + 2 + 2*i, (i == NL-1)});
          rdq.push_back('{a, cyc + 2*i});
        end
        busy_start = cyc; free_at = cyc + 2*NL + 1;
        mask_lane = NL - 1; mask_cyc = free_at;
      end else if (pend != '0) begin
        lane = -1;
        for (int k = 0; k < NL; k++)
          if (lane < 0 && pend[(mptr + k) % NL]) lane = (mptr + k) % NL;
        a = tile_base + AW'(lane);
        ackq.push_back('{lane, sram[a], cyc + 2, 1'b0});
        rdq.push_back('{a, cyc});
        mptr = (lane + 1) % NL;
        busy_start = cyc; free_at = cyc + 3;
        mask_lane = lane; mask_cyc = free_at;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clock) begin
    logic [NL*DW-1:0] exp_bus;
    ack_exp_t e;
    if (!reset) begin
      check_bus("rst_lanes", weights_data_out, '0);
      check("rst_ack", 64'(weights_ack), 64'(0));
      check("rst_done", 64'(load_done), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_rd_en", 64'(mem_rd_en), 64'(0));
      check("rst_addr", 64'(mem_addr), 64'(0));
    end else begin
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        check("rd_en", 64'(mem_rd_en), 64'(1));
        check("rd_addr", 64'(mem_addr), 64'(rdq[0].addr));
        void'(rdq.pop_front());
      end else begin
        check("rd_unexpected", 64'(mem_rd_en), 64'(0));
      end
      if (mem_rd_en) reads_seen++;
      if (weights_ack != '0 || load_done) begin
        if (ackq.size() == 0) begin
          check("ack_spurious", 64'(weights_ack), 64'(0));
          check("done_spurious", 64'(load_done), 64'(0));
        end else begin
          e = ackq.pop_front();
          check("ack_cycle", 64'(cyc), 64'(e.cyc));
          check("ack_lane", 64'(weights_ack), 64'(1) << e.lane);
          check("ack_done", 64'(load_done), 64'(e.done));
          mlanes[e.lane] = e.data;
        end
        if (load_done) check("bulk_cycles", 64'(cyc - busy_rise), 64'(2*NL));
        acked_accum |= weights_ack;
      end else if (ackq.size() > 0 && ackq[0].cyc <= cyc) begin
        e = ackq.pop_front();
        check("ack_missing", 64'(0), 64'(1) << e.lane);
        mlanes[e.lane] = e.data;
      end
      check("busy", 64'(busy), 64'(cyc >= busy_start && cyc < free_at - 1));
      for (int i = 0; i < NL; i++) exp_bus[i*DW +: DW] = mlanes[i];
      check_bus("lanes", weights_data_out, exp_bus);
      if (busy && !busy_prev) busy_rise = cyc;
    end
    busy_prev = busy;
  end

  // MACs drop a request one cycle after its ack.
  task automatic step();
    @(posedge clock);
    #1;
    weights_request = weights_request & ~acked_accum;
    acked_accum = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(ackq.size() == 0 && rdq.size() == 0 && cyc >= free_at && weights_request == '0)
           && n < 2000) begin
      step();
      n++;
    end
    check({name, "_timeout"}, 64'(n < 2000), 64'(1));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    for (int a = 0; a < 4096; a++) sram[a] = DW'(a);
    model_reset();
    #2 reset = 1'b0;
    repeat (5) begin
      step();
      weights_request = {$urandom, $urandom};
      tile_base = AW'($urandom);
      load_all = 1'($urandom);
    end
    step();
    weights_request = '0; load_all = 1'b0; tile_base = '0;
    step();
    reset = 1'b1;
    repeat (5) step();

    // Single request
    sram[12'h105] = 8'hA5;
    tile_base = 12'h100;
    weights_request[5] = 1'b1;
    wait_idle("single");
    check("single_lane5", 64'(weights_data_out[5*DW +: DW]), 64'(8'hA5));
    check("single_lane4", 64'(weights_data_out[4*DW +: DW]), 64'(0));

    // Round robin from pointer 0, then wrap
    do_reset();
    weights_request[3] = 1'b1;
    weights_request[60] = 1'b1;
    wait_idle("rr1");
    weights_request[60] = 1'b1;
    weights_request[2] = 1'b1;
    wait_idle("rr2");

    // Bulk refill across the address wrap; tile_base change mid-sweep
    tile_base = 12'hFF0;
    load_all = 1'b1;
    step();
    load_all = 1'b0;
    tile_base = 12'h3A7;
    wait_idle("bulk");
    check("bulk_lane0", 64'(weights_data_out[0*DW +: DW]), 64'(8'hF0));
    check("bulk_lane15", 64'(weights_data_out[15*DW +: DW]), 64'(8'hFF));
    check("bulk_lane16", 64'(weights_data_out[16*DW +: DW]), 64'(8'h00));
    check("bulk_lane63", 64'(weights_data_out[63*DW +: DW]), 64'(8'h2F));

    // Reset during CAPTURE of lane 7
    weights_request[7] = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("midrst_ack", 64'(weights_ack), 64'(0));
    check("midrst_lane7", 64'(weights_data_out[7*DW +: DW]), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    step();
    reset = 1'b1;
    wait_idle("after_rst");
    check("after_rst_lane7", 64'(weights_data_out[7*DW +: DW]), 64'(8'hAE));

    // One fetch per request
    rd0 = reads_seen;
    weights_request[20] = 1'b1;
    wait_idle("mask");
    repeat (5) step();
    check("mask_single_read", 64'(reads_seen - rd0), 64'(1));

    // Randomised traffic
    for (int a = 0; a < 4096; a++) sram[a] = DW'($urandom);
    for (int t = 0; t < 3000; t++) begin
      step();
      if ($urandom_range(0, 3) == 0) weights_request[$urandom_range(0, NL-1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) weights_request[$urandom_range(0, NL-1)] = 1'b0;
      if ($urandom_range(0, 7) == 0) tile_base = AW'($urandom);
      load_all = ($urandom_range(0, 199) == 0);
    end
    step();
    load_all = 1'b0;
    weights_request = '0;
    wait_idle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_fetch_unit.md
Name: weight_fetch_unit

Overview:
- Serves the per-MAC weight request bus of the systolic MAC matrix.
- Each asserted request bit is answered with one weight, read from the weight SRAM at address tile_base + MAC index.
- The weight is placed in that MAC's byte lane of the packed weight bus, and a one-cycle ack is returned to that MAC.
- Also provides a bulk load_all sweep that refills all lanes at tile change.

Parameters:
- DATA_SIZE, 8, bits per weight.
- MAC_WIDTH, 8, matrix edge; N = MAC_WIDTH*MAC_WIDTH request lanes (64).
- ADDR_WIDTH, 12, weight SRAM address width.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- weights_request  in  N  level request per MAC, index i = row*MAC_WIDTH+col; held until the matching ack.
- weights_data_out  out  N*DATA_SIZE  packed weights; lane i = bits [i*DATA_SIZE +: DATA_SIZE].
- weights_ack  out  N  one-hot, one-cycle pulse: lane i just updated.
- tile_base  in  ADDR_WIDTH  SRAM base of current weight tile; sampled when a fetch is picked.
- load_all  in  1  bulk refill command, sampled only in IDLE.
- load_done  out  1  one-cycle pulse at end of a bulk refill.
- busy  out  1  high whenever state != IDLE.
- mem_rd_en  out  1  SRAM read strobe.
- mem_addr  out  ADDR_WIDTH  SRAM read address.
- mem_rd_data  in  DATA_SIZE  SRAM data, valid exactly one cycle after mem_rd_en.

Behaviour:
- Reset (reset=0, async): all outputs are 0, including every lane of weights_data_out. State = IDLE, rr_ptr = 0, bulk flag cleared. An in-flight read is abandoned; no ack is issued for it.
- Request mask: pending = weights_request & ~weights_ack. The lane acked in the current cycle is never re-picked in that same cycle.
- FSM states are IDLE, ISSUE, CAPTURE.
- IDLE, when load_all=1: set the bulk flag, idx=0, latch tile_base, go to ISSUE. load_all has priority over pending requests.
- IDLE, otherwise when pending != 0: idx = first set bit of pending, searching upward from rr_ptr with wrap at N. Latch tile_base, go to ISSUE.
- ISSUE: mem_rd_en=1, mem_addr = latched base + idx, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH). Go to CAPTURE.
- CAPTURE: mem_rd_en=0. At the closing edge, write mem_rd_data into lane idx. weights_ack[idx]=1 for the next cycle only.
  - Request mode: rr_ptr = (idx+1) mod N, return to IDLE.
  - Bulk mode with idx < N-1: idx+1, go to ISSUE.
  - Bulk mode with idx = N-1: clear the bulk flag, pulse load_done together with ack[N-1], return to IDLE.
- Latency: request seen at edge k gives rd_en in cycle k+1, data in cycle k+2, lane update and ack in cycle k+3. Throughput is one weight per 3 cycles in request mode.
- Bulk refill takes 2N cycles (128) from leaving IDLE to load_done.
- Lanes not being written hold their value. Lanes change only via CAPTURE or reset.
- A request that drops before service is simply not served; there is no stale ack.
- A request that rises during bulk mode is not separately served if its lane was already refilled by the sweep. It is seen in IDLE afterwards and served again; this is legal.
- tile_base changes while busy: no effect on the current fetch. Applies from the next pick.
- load_all while busy: ignored. Callers wait for busy=0.
- Acks are one-hot by construction.

Decomposition:
- Shared package tpu_pkg holds:
  - DATA_SIZE and MAC_WIDTH constants, also used by mac_matrix.
  - The derived N.
  - State encoding: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2.
- Sub-module rr_arbiter (N-bit request, pointer in, one-hot grant plus encoded index, any flag). Purely combinational, instantiated once.
- The pointer register stays in weight_fetch_unit.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0. Release with no requests → busy stays 0, mem_rd_en stays 0.
- Single request: tile_base=0x100, request[5] raised at edge k, SRAM returns 0xA5 → mem_addr=0x105 with rd_en in cycle k+1; lane 5 = 0xA5 and ack=1<<5 in cycle k+3; other lanes unchanged.
- Round robin: request[3] and request[60] held, rr_ptr=0 → lane 3 served first (ack cycle k+3), then lane 60 (ack cycle k+6), then rr_ptr=61. With request[60] and request[2] next → 2 is picked after 60 via wrap.
- Bulk: load_all with tile_base=0xFF0, SRAM data = addr[7:0] → 64 reads at addresses 0xFF0..0xFFF then 0x000..0x02F (wrap). Lane i = (0xF0+i) mod 256. load_done is co-incident with ack[63], 128 cycles after leaving IDLE.
- Reset mid-op: assert reset during CAPTURE of lane 7 → no ack; lane 7 is 0 and busy is 0 immediately. With request[7] still high after release → served normally.
- Masking: MAC drops its request one cycle after its ack → exactly one fetch per request; no double read.
